// File: rtl/uart_tx_arbiter.sv
// Arbitrates the shared UART transmitter between the filtered PS/2 scancode FIFO
// and the single-entry switch holding register, one tx_start per byte.
module uart_tx_arbiter #(
  parameter int KBD_DEPTH = 4,
  parameter int BUSY_WAIT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   kbd_data,
  input  logic                         kbd_valid,
  input  logic [7:0]                   sw_data,
  input  logic                         sw_valid,
  input  logic                         tx_busy,
  output logic [7:0]                   tx_data,
  output logic                         tx_start,
  output logic                         grant_src,
  output logic [$clog2(KBD_DEPTH):0]   kbd_count,
  output logic                         sw_pending,
  output logic [7:0]                   drop_count,
  output logic                         timeout
);

  localparam int AW = $clog2(KBD_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(BUSY_WAIT + 2);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic            skip;
  logic [7:0]      kbd_mem [KBD_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      sw_byte;

  logic kbd_pending;
  logic kbd_full;
  logic grant;
  logic pick_sw;
  logic pop_kbd;
  logic pop_sw;
  logic kbd_push_req;
  logic kbd_push;
  logic kbd_drop;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    kbd_pending  = (kbd_count != '0);
    kbd_full     = (kbd_count == CW'(KBD_DEPTH));
    grant        = (state == IDLE) && (kbd_pending || sw_pending);
    // On a tie the source that did not win last time goes next.
    pick_sw      = sw_pending && (!kbd_pending || !grant_src);
    pop_kbd      = grant && !pick_sw;
    pop_sw       = grant && pick_sw;
    kbd_push_req = kbd_valid && !skip && (kbd_data != 8'hF0);
    kbd_push     = kbd_push_req && (!kbd_full || pop_kbd);
    kbd_drop     = kbd_push_req && !kbd_push;
  end

  // NOTE: the FIFO storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (kbd_push) kbd_mem[wr_ptr] <= kbd_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      kbd_count  <= '0;
      drop_count <= 8'h00;
      sw_byte    <= 8'h00;
      sw_pending <= 1'b0;
    end else begin
      if (kbd_valid) begin
        if (skip)                   skip <= 1'b0;
        else if (kbd_data == 8'hF0) skip <= 1'b1;
      end
      if (kbd_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop_kbd)  rd_ptr <= rd_ptr + AW'(1);
      case ({kbd_push, pop_kbd})
        2'b10:   kbd_count <= kbd_count + CW'(1);
        2'b01:   kbd_count <= kbd_count - CW'(1);
        default: kbd_count <= kbd_count;
      endcase
      if (kbd_drop && drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
      // A new switch byte wins over a pop in the same cycle.
      if (sw_valid) begin
        sw_byte    <= sw_data;
        sw_pending <= 1'b1;
      end else if (pop_sw) begin
        sw_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      tx_data   <= 8'h00;
      tx_start  <= 1'b0;
      grant_src <= 1'b1;
      timeout   <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            tx_data   <= pick_sw ? sw_byte : kbd_mem[rd_ptr];
            grant_src <= pick_sw;
            tx_start  <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == WW'(BUSY_WAIT)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
